// File: rtl/rs_pkg.sv
// Shared types and helpers for the multi-entry reservation station.
// Holds the dispatch/CDB/issue packet formats, the per-entry state record
// and the tag-match helper used by both dispatch bypass and wakeup.
package rs_pkg;

  localparam int ROB_TAG_LEN = 4;
  localparam int TAG_W = ROB_TAG_LEN + 1;

  localparam int RS_MIN_ENTRIES = 2;
  localparam int RS_MAX_ENTRIES = 16;
  localparam int RS_MAX_AGE_W = $clog2(RS_MAX_ENTRIES);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [3:0]  alu_func;
    logic        rd_mem;
    logic        wr_mem;
  } ID_EX_PACKET;

  typedef struct packed {
    logic [TAG_W-1:0] rob_tag_val;
    logic             rob_tag_ready;
  } MAPTABLE_PACKET;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] rob_tag;
    logic [31:0]      value;
  } CDB_DATA;

  typedef struct packed {
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] rs1_tag;
    logic [TAG_W-1:0] rs2_tag;
    logic [31:0]      rs1_value;
    logic [31:0]      rs2_value;
    ID_EX_PACKET      packet;
  } INSTR_READY_ENTRY;

  // Ages are stored at the widest supported width so one record type serves
  // every instance size; the unused upper bits simply stay zero.
  typedef struct packed {
    logic                    valid;
    logic [RS_MAX_AGE_W-1:0] age;
    logic [TAG_W-1:0]        rs1_tag;
    logic [31:0]             rs1_value;
    logic                    rs1_ready;
    logic [TAG_W-1:0]        rs2_tag;
    logic [31:0]             rs2_value;
    logic                    rs2_ready;
    logic [TAG_W-1:0]        rd_tag;
    ID_EX_PACKET             packet;
  } RS_ENTRY;

  function automatic logic match_tag(input logic [TAG_W-1:0] tag, input CDB_DATA cdb);
    return cdb.valid && (tag == cdb.rob_tag);
  endfunction

endpackage

// File: rtl/rs_oldest_select.sv
// Oldest-ready picker: among the requesting entries, grant the one with the
// largest age; equal ages resolve to the lowest index.
module rs_oldest_select
  import rs_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int IDX_W = $clog2(NUM_ENTRIES)
) (
  input  logic [NUM_ENTRIES-1:0]                   ready,
  input  logic [NUM_ENTRIES-1:0][RS_MAX_AGE_W-1:0] ages,
  output logic [NUM_ENTRIES-1:0]                   grant,
  output logic [IDX_W-1:0]                         index
);

  logic                    found;
  logic [RS_MAX_AGE_W-1:0] best_age;

  // Linear scan; strict greater-than keeps the earliest index on a tie.
  always_comb begin
    found = 1'b0;
    best_age = '0;
    index = '0;
    grant = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (ready[i] && (!found || (ages[i] > best_age))) begin
        found = 1'b1;
        best_age = ages[i];
        index = IDX_W'(i);
      end
    end
    grant[index] = found;
  end

endmodule

// File: rtl/multi_entry_rs.sv
// N-entry reservation station feeding one functional-unit issue port.
// Captures operands at dispatch (regfile, ROB or same-cycle CDB bypass),
// wakes waiting operands from CDB broadcasts and issues the oldest ready
// entry under a valid/ready handshake. squash empties the station.
// Optional build macro RS_CDB_ISSUE_BYPASS_EN: an entry whose only missing
// gating operands match the live CDB broadcast is issuable this cycle, with
// the broadcast value substituted on the output.
module multi_entry_rs
  import rs_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int NO_WAIT_RS2 = 0,
  parameter int AGE_W = $clog2(NUM_ENTRIES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  ID_EX_PACKET       id_packet_out,
  input  MAPTABLE_PACKET    maptable_packet_rs1,
  input  MAPTABLE_PACKET    maptable_packet_rs2,
  input  logic [31:0]       rob_rs1_value,
  input  logic [31:0]       rob_rs2_value,
  input  logic [TAG_W-1:0]  alloc_slot,
  input  CDB_DATA           cdb,
  input  logic              squash,
  input  logic              issue_ready,
  output logic              issue_valid,
  output INSTR_READY_ENTRY  ready_inst_entry,
  output logic              rs_full,
  output logic [AGE_W:0]    free_count
);

  localparam logic [RS_MAX_AGE_W-1:0] AGE_MAX = RS_MAX_AGE_W'(NUM_ENTRIES - 1);
  localparam logic RS2_NO_GATE = (NO_WAIT_RS2 != 0);

  RS_ENTRY entries_q [NUM_ENTRIES];
  RS_ENTRY entries_d [NUM_ENTRIES];
  RS_ENTRY new_entry;
  RS_ENTRY sel_entry;

  logic [32:0] rs1_src;
  logic [32:0] rs2_src;

  logic [NUM_ENTRIES-1:0]                   hit_rs1;
  logic [NUM_ENTRIES-1:0]                   hit_rs2;
  logic [NUM_ENTRIES-1:0]                   ready_vec;
  logic [NUM_ENTRIES-1:0]                   grant;
  logic [NUM_ENTRIES-1:0][RS_MAX_AGE_W-1:0] age_vec;
  logic [NUM_ENTRIES-1:0]                   free_onehot;
  logic [AGE_W-1:0]                         sel_idx;
  logic [AGE_W:0]                           free_cnt;
  logic                                     free_found;
  logic                                     dispatch_fire;
  logic                                     issue_fire;

  // Returns {ready, value}; sources are tried in priority order.
  function automatic logic [32:0] resolve_operand(input MAPTABLE_PACKET mp,
                                                  input logic [31:0] rf_value,
                                                  input logic [31:0] rob_value,
                                                  input CDB_DATA bus);
    if (mp.rob_tag_val == '0)
      return {1'b1, rf_value};
    else if (mp.rob_tag_ready)
      return {1'b1, rob_value};
    else if (match_tag(mp.rob_tag_val, bus))
      return {1'b1, bus.value};
    else
      return {1'b0, 32'd0};
  endfunction

  // Build the record written into the free slot on a dispatch.
  always_comb begin
    rs1_src = resolve_operand(maptable_packet_rs1, id_packet_out.rs1_value, rob_rs1_value, cdb);
    rs2_src = resolve_operand(maptable_packet_rs2, id_packet_out.rs2_value, rob_rs2_value, cdb);
    new_entry = '0;
    new_entry.valid = 1'b1;
    new_entry.age = '0;
    new_entry.rs1_tag = maptable_packet_rs1.rob_tag_val;
    new_entry.rs1_value = rs1_src[31:0];
    new_entry.rs1_ready = rs1_src[32];
    new_entry.rs2_tag = maptable_packet_rs2.rob_tag_val;
    new_entry.rs2_value = rs2_src[31:0];
    new_entry.rs2_ready = rs2_src[32];
    new_entry.rd_tag = alloc_slot;
    new_entry.packet = id_packet_out;
  end

  // Occupancy: free count, full flag and the lowest-index free slot.
  always_comb begin
    free_cnt = '0;
    free_onehot = '0;
    free_found = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!entries_q[i].valid) begin
        free_cnt = free_cnt + (AGE_W + 1)'(1);
        if (!free_found) begin
          free_onehot[i] = 1'b1;
          free_found = 1'b1;
        end
      end
    end
  end

  assign free_count = free_cnt;
  assign rs_full = (free_cnt == '0);
  assign dispatch_fire = enable && !rs_full && !squash;

  // Per-entry CDB match on still-waiting operands, and issue readiness.
  always_comb begin
    hit_rs1 = '0;
    hit_rs2 = '0;
    ready_vec = '0;
    age_vec = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      hit_rs1[i] = !entries_q[i].rs1_ready && match_tag(entries_q[i].rs1_tag, cdb);
      hit_rs2[i] = !entries_q[i].rs2_ready && match_tag(entries_q[i].rs2_tag, cdb);
      age_vec[i] = entries_q[i].age;
`ifdef RS_CDB_ISSUE_BYPASS_EN
      ready_vec[i] = entries_q[i].valid
                     && (entries_q[i].rs1_ready || hit_rs1[i])
                     && (entries_q[i].rs2_ready || RS2_NO_GATE || hit_rs2[i]);
`else
      ready_vec[i] = entries_q[i].valid && entries_q[i].rs1_ready
                     && (entries_q[i].rs2_ready || RS2_NO_GATE);
`endif
    end
  end

  rs_oldest_select #(
    .NUM_ENTRIES(NUM_ENTRIES),
    .IDX_W(AGE_W)
  ) u_select (
    .ready(ready_vec),
    .ages(age_vec),
    .grant(grant),
    .index(sel_idx)
  );

  assign issue_valid = |ready_vec;
  assign issue_fire = issue_valid && issue_ready;

  // Present the selected entry; all-zero when nothing is issuable.
  always_comb begin
    sel_entry = entries_q[sel_idx];
    ready_inst_entry = '0;
    if (issue_valid) begin
      ready_inst_entry.rd_tag = sel_entry.rd_tag;
      ready_inst_entry.rs1_tag = sel_entry.rs1_tag;
      ready_inst_entry.rs2_tag = sel_entry.rs2_tag;
      ready_inst_entry.rs1_value = sel_entry.rs1_value;
      ready_inst_entry.rs2_value = sel_entry.rs2_value;
      ready_inst_entry.packet = sel_entry.packet;
`ifdef RS_CDB_ISSUE_BYPASS_EN
      if (hit_rs1[sel_idx])
        ready_inst_entry.rs1_value = cdb.value;
      if (hit_rs2[sel_idx])
        ready_inst_entry.rs2_value = cdb.value;
`endif
    end
  end

  // Next entry state: issue frees, CDB wakes, dispatch ages and writes;
  // squash last so it overrides everything else.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      entries_d[i] = entries_q[i];
      if (issue_fire && grant[i])
        entries_d[i].valid = 1'b0;
      if (hit_rs1[i]) begin
        entries_d[i].rs1_value = cdb.value;
        entries_d[i].rs1_ready = 1'b1;
      end
      if (hit_rs2[i]) begin
        entries_d[i].rs2_value = cdb.value;
        entries_d[i].rs2_ready = 1'b1;
      end
      if (dispatch_fire && entries_q[i].valid && (entries_q[i].age != AGE_MAX))
        entries_d[i].age = entries_q[i].age + RS_MAX_AGE_W'(1);
      if (dispatch_fire && free_onehot[i])
        entries_d[i] = new_entry;
      if (squash)
        entries_d[i].valid = 1'b0;
    end
  end

  // Entry storage with synchronous reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (reset)
        entries_q[i] <= '0;
      else
        entries_q[i] <= entries_d[i];
    end
  end

endmodule

// File: doc/multi_entry_rs.md
Name: multi_entry_rs

Overview:
- Parametrised N-entry reservation station. Successor to the single-slot RS.
- Sits between dispatch (decode packet plus map-table lookup) and one functional-unit issue port. ST/LD and ALU instances differ only in NO_WAIT_RS2.
- Holds up to NUM_ENTRIES instructions, wakes operands from CDB broadcasts, and issues the oldest ready entry under a valid/ready handshake.
- Supports full-pipeline squash.

Parameters:
- NUM_ENTRIES, 4: entry count, power of two, 2..16.
- NO_WAIT_RS2, 0: 1 = rs2 never gates readiness (store data / load), rs2 still captured if available.
- AGE_W, $clog2(NUM_ENTRIES): age counter width (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- enable  in  1  dispatch request this cycle
- id_packet_out  in  ID_EX_PACKET  decoded instruction incl. rs1_value/rs2_value from regfile
- maptable_packet_rs1  in  MAPTABLE_PACKET  rs1 producer tag / ready flag
- maptable_packet_rs2  in  MAPTABLE_PACKET  rs2 producer tag / ready flag
- rob_rs1_value  in  32  rs1 value read from ROB when rob_tag_ready=1
- rob_rs2_value  in  32  rs2 value read from ROB when rob_tag_ready=1
- alloc_slot  in  `ROB_TAG_LEN+1  destination ROB tag (rd_tag)
- cdb  in  CDB_DATA  broadcast: valid, rob_tag, value
- squash  in  1  flush all entries
- issue_ready  in  1  FU accepts issue this cycle
- issue_valid  out  1  ready_inst_entry is valid
- ready_inst_entry  out  INSTR_READY_ENTRY  selected instruction
- rs_full  out  1  all entries valid
- free_count  out  AGE_W+1  number of invalid entries

Behaviour:
- Reset (synchronous, active-high) clears all valid bits and ages. After reset: issue_valid=0, ready_inst_entry=0, rs_full=0, free_count=NUM_ENTRIES.
- Operand source at dispatch, per rsX, first match wins:
  - rob_tag_val==0: value from id_packet_out.rsX_value, ready.
  - rob_tag_ready==1: value from rob_rsX_value, ready.
  - cdb.valid and cdb.rob_tag==rob_tag_val: value from cdb.value, ready (same-cycle bypass).
  - otherwise: store tag, not ready.
- Dispatch: when enable && !rs_full && !squash, write lowest-index free entry at the edge. rd_tag=alloc_slot, age=0.
  - All other valid entries age+1, saturating at NUM_ENTRIES-1.
  - enable while rs_full is ignored; upstream must stall.
- Wakeup: at each edge, every valid entry with an unready operand whose tag==cdb.rob_tag (cdb.valid=1) captures cdb.value and sets ready. Both operands may wake on the same broadcast.
- Ready condition: valid && rs1_ready && (rs2_ready || NO_WAIT_RS2).
- Select: combinational from registered state. Pick the ready entry with the largest age; ties go to the lowest index.
  - issue_valid=1 iff any entry is ready.
  - ready_inst_entry carries rd_tag, rs1/rs2 tags, rs1/rs2 values and the packet.
  - ready_inst_entry is 0 when issue_valid=0.
- Latency: an entry with all operands ready at dispatch edge N is issuable in cycle N+1. A CDB wakeup at edge M makes the entry issuable in cycle M+1.
- Issue handshake: issue_valid && issue_ready frees the selected entry at the edge. The output must stay stable while issue_valid && !issue_ready, unless an older entry becomes ready.
- Dispatch and issue in the same cycle are both performed. rs_full is computed from registered state, so a freeing issue does not admit dispatch in the same cycle.
- squash: clears all valid bits at the edge. It overrides dispatch, wakeup and issue; issue_valid=0 the next cycle.
- free_count and rs_full are derived from registered valid bits only.

Optional Feature:
- Macro RS_CDB_ISSUE_BYPASS_EN.
- Defined: an entry missing exactly its gating operand(s), all matching the current valid cdb.rob_tag, counts as ready this cycle. Its output takes cdb.value for the matching operand(s), saving one cycle.
- Undefined: readiness comes only from registered state (latency as above).

Decomposition:
- Shared package rs_pkg holds:
  - RS_ENTRY typedef: valid, age, rs1/rs2 tag, value and ready, rd_tag, packet.
  - Function match_tag(tag, cdb).
  - Entry-count localparams.
- Sub-module rs_oldest_select: inputs ready vector and ages; outputs a one-hot grant and an index.

Test Plan:
- Reset then dispatch ld (rs1 tag 0, rs1_value=5, alloc_slot=1) on the NO_WAIT_RS2=1 instance -> next cycle issue_valid=1, rd_tag=1, rs1_value=5.
- ALU instance: dispatch mul (rs1_value=10, rs2 tag 1 not ready, alloc_slot=2); two cycles later cdb{1,1,5} -> issue_valid=1 the cycle after the broadcast, rs2_value=5, rs1_value=10, rd_tag=2.
- Fill 4 entries (tags 3..6, all ready) with issue_ready=0 -> rs_full=1, free_count=0, 5th dispatch dropped. Raise issue_ready -> issue order 3,4,5,6.
- Dispatch with rs2 tag 7 while cdb{1,7,99} is on the bus -> entry stores rs2_value=99, ready next cycle.
- Two waiting entries, both on tag 4; cdb{1,4,9} -> both wake, older issues first.
- squash with 3 valid entries plus a simultaneous dispatch -> next cycle free_count=4, issue_valid=0.
